// File: rtl/fifo_sync.sv
// Single-clock FIFO with push/pop handshake, full/empty flags and registered read data.
// Pointers carry one extra wrap bit so full and empty are distinguishable at equal addresses.
module fifo_sync #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_full,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_empty
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic                  push_ok, pop_ok;

    // Flags depend only on registered pointers, so push/pop never reach an output combinationally.
    assign r_empty = (wptr_q == rptr_q);
    assign w_full  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                     (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);

    assign push_ok = push && !w_full;
    assign pop_ok  = pop && !r_empty;
    assign r_data  = r_data_q;

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        r_data_d = r_data_q;
        if (push_ok) begin
            wptr_d = wptr_q + (ADDR_WIDTH + 1)'(1);
        end
        if (pop_ok) begin
            rptr_d   = rptr_q + (ADDR_WIDTH + 1)'(1);
            r_data_d = mem[rptr_q[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            r_data_q <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            r_data_q <= r_data_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_q[ADDR_WIDTH-1:0]] <= w_data;
        end
    end

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync: a vector table for short sequences, then a
// queue-based scoreboard for reset, overfill, drain, underflow and concurrent traffic.
module tb_fifo_sync;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic          w_full;
    logic [DW-1:0] r_data;
    logic          r_empty;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_rd;

    typedef struct {
        logic          push;
        logic          pop;
        logic [DW-1:0] w_data;
        logic [DW-1:0] exp_rd;
        logic          exp_empty;
        logic          exp_full;
    } vec_t;

    vec_t vecs [8];

    fifo_sync #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .w_data (w_data),
        .w_full (w_full),
        .pop    (pop),
        .r_data (r_data),
        .r_empty(r_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock with scoreboard prediction; flags qualify against the pre-edge occupancy.
    task automatic cycle(input logic p, input logic q, input logic [DW-1:0] d, input string tag);
        bit acc_push;
        bit acc_pop;
        acc_push = p && (sb.size() < DEPTH);
        acc_pop  = q && (sb.size() > 0);
        push   = p;
        pop    = q;
        w_data = d;
        if (acc_pop) exp_rd = sb.pop_front();
        if (acc_push) sb.push_back(d);
        @(posedge clk);
        #1;
        check({tag, " r_data"}, 32'(r_data), 32'(exp_rd));
        check({tag, " r_empty"}, 32'(r_empty), 32'(sb.size() == 0));
        check({tag, " w_full"}, 32'(w_full), 32'(sb.size() == DEPTH));
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0}; // pop on empty
        vecs[1] = '{1'b1, 1'b1, 16'h0011, 16'h0000, 1'b0, 1'b0}; // push+pop on empty
        vecs[2] = '{1'b1, 1'b0, 16'h0022, 16'h0000, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 16'h0033, 16'h0011, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 16'h0000, 16'h0022, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 16'h0000, 16'h0033, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'h0000, 16'h0033, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 16'h0000, 16'h0033, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset r_empty", 32'(r_empty), 32'd1);
        check("reset w_full", 32'(w_full), 32'd0);
        check("reset r_data", 32'(r_data), 32'd0);

        for (int i = 0; i < 8; i++) begin
            push   = vecs[i].push;
            pop    = vecs[i].pop;
            w_data = vecs[i].w_data;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d r_data", i), 32'(r_data), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d r_empty", i), 32'(r_empty), 32'(vecs[i].exp_empty));
            check($sformatf("vec%0d w_full", i), 32'(w_full), 32'(vecs[i].exp_full));
        end
        push   = 1'b0;
        pop    = 1'b0;
        exp_rd = 16'h0033;

        // Mid-operation reset with 10 words stored; effect must be immediate.
        for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0, 16'(16'h0a00 + i), "preload");
        cycle(1'b0, 1'b1, '0, "preload pop");
        #3;
        rst = 1'b1;
        #1;
        check("async reset r_empty", 32'(r_empty), 32'd1);
        check("async reset w_full", 32'(w_full), 32'd0);
        check("async reset r_data", 32'(r_data), 32'd0);
        sb.delete();
        exp_rd = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b0, 1'b1, '0, "post-reset pop");

        // Overfill: 300 pushes, the last 44 dropped.
        for (int i = 1; i <= 300; i++) cycle(1'b1, 1'b0, 16'(i), $sformatf("overfill%0d", i));

        // Push+pop while full: one word read, push dropped, full clears.
        cycle(1'b1, 1'b1, 16'hbeef, "full pair");
        check("full pair word", 32'(r_data), 32'd1);

        // Drain the rest, then underflow.
        while (sb.size() > 0) cycle(1'b0, 1'b1, '0, "drain");
        check("drain last word", 32'(r_data), 32'd256);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, '0, "underflow");
        check("underflow holds", 32'(r_data), 32'd256);

        // Concurrent traffic across pointer wraps with 5 words in flight.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'(16'h1000 + i), "prefill");
        for (int i = 5; i < 1005; i++) cycle(1'b1, 1'b1, 16'(16'h1000 + i), "concurrent");
        while (sb.size() > 0) cycle(1'b0, 1'b1, '0, "final drain");
        check("final word", 32'(r_data), 32'(16'h1000 + 1004));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
